// File: rtl/ag6502_ext_clock.sv
// Two-phase non-overlapping CPU clock generator: synchronizes clk1 into the clk domain
// and emits phi_1 / phi_2 separated by a dead gap of DELAY clk periods.
module ag6502_ext_clock #(
   parameter int DELAY       = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clk1,
   output logic phi_1,
   output logic phi_2
);

   localparam int CNT_W = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY);

   generate
      if (DELAY < 1) begin : g_bad_delay
         $error("ag6502_ext_clock: DELAY must be >= 1");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("ag6502_ext_clock: SYNC_STAGES must be >= 2");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   s_next;
   logic [CNT_W-1:0]       cnt;
   logic                   gap_done;

   assign s        = sync[SYNC_STAGES-1];
   assign s_next   = sync[SYNC_STAGES-2];
   assign gap_done = (cnt == CNT_MAX);

   // Synchronizer: clk1 is asynchronous to clk, s is the last stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], clk1};
      end
   end

   // Gap counter restarts whenever s is about to change, so a glitch re-arms the full gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (s_next != s) begin
         cnt <= '0;
      end else if (!gap_done) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Output phases: mutually exclusive because they are gated by s and its complement
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phi_1 <= 1'b0;
         phi_2 <= 1'b0;
      end else begin
         phi_1 <= ~s & gap_done;
         phi_2 <= s & gap_done;
      end
   end

endmodule

// File: tb/tb_ag6502_ext_clock.sv
// Testbench for ag6502_ext_clock: four instances (different DELAY / SYNC_STAGES) checked
// against a window-based reference model of the two-phase clock rules.
module tb_ag6502_ext_clock;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clk1;
   logic [3:0] p1;
   logic [3:0] p2;
   logic [3:0] e1;
   logic [3:0] e2;

   int dl [4] = '{1, 2, 3, 1};
   int sy [4] = '{2, 2, 2, 3};

   bit hq[$];
   int n;
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ag6502_ext_clock #(.DELAY(1), .SYNC_STAGES(2)) u_d1 (
      .clk(clk), .rst_n(rst_n), .clk1(clk1), .phi_1(p1[0]), .phi_2(p2[0]));
   ag6502_ext_clock #(.DELAY(2), .SYNC_STAGES(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .clk1(clk1), .phi_1(p1[1]), .phi_2(p2[1]));
   ag6502_ext_clock #(.DELAY(3), .SYNC_STAGES(2)) u_d3 (
      .clk(clk), .rst_n(rst_n), .clk1(clk1), .phi_1(p1[2]), .phi_2(p2[2]));
   ag6502_ext_clock #(.DELAY(1), .SYNC_STAGES(3)) u_s3 (
      .clk(clk), .rst_n(rst_n), .clk1(clk1), .phi_1(p1[3]), .phi_2(p2[3]));

   // Synchronized clk1 value after edge k (edge 0 = reset state, chain starts at 0)
   function automatic bit sval(int k, int st);
      if (k >= st) return hq[k - st];
      return 1'b0;
   endfunction

   task automatic model_reset();
      n = 0;
      hq.delete();
      e1 = '0;
      e2 = '0;
   endtask

   // One clk cycle; a phase is expected high when the synchronized level has held
   // for the last DELAY+1 edge values
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         n++;
         hq.push_back(clk1);
         for (int i = 0; i < 4; i++) begin
            bit v;
            bit stable;
            e1[i] = 1'b0;
            e2[i] = 1'b0;
            if (n - 1 - dl[i] >= 0) begin
               v = sval(n - 1, sy[i]);
               stable = 1'b1;
               for (int j = n - 1 - dl[i]; j <= n - 1; j++)
                  if (sval(j, sy[i]) != v) stable = 1'b0;
               if (stable) begin
                  if (v) e2[i] = 1'b1;
                  else   e1[i] = 1'b1;
               end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clk1  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({p1, p2} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_value: phi_1=%b phi_2=%b, expected 0000 0000", p1, p2);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (p1[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL release_edge1: phi_1=%b, expected 0", p1[0]);
      end
      tick();
      n_checks++;
      if (p1[0] !== 1'b1 || p2 !== 4'b0000) begin
         n_fail++;
         $display("FAIL release_edge2: phi_1=%b phi_2=%b, expected 1 0000", p1[0], p2);
      end
      repeat (12) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (p1[i] !== e1[i] || p2[i] !== e2[i]) begin
               n_fail++;
               $display("FAIL reset_model u%0d edge %0d: phi_1=%b phi_2=%b, expected %b %b",
                        i, n, p1[i], p2[i], e1[i], e2[i]);
            end
         end
      end
   endtask

   task automatic test_1mhz();
      int c1 [4];
      int c2 [4];
      for (int i = 0; i < 4; i++) begin
         c1[i] = 0;
         c2[i] = 0;
      end
      for (int per = 0; per < 4; per++) begin
         for (int k = 1; k <= 50; k++) begin
            clk1 = (k <= 25);
            tick();
            if (per == 0 && k == 3) begin
               n_checks++;
               if (p1[0] !== 1'b0 || p2[0] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL mhz_gap: phi_1=%b phi_2=%b, expected 0 0", p1[0], p2[0]);
               end
            end
            if (per == 0 && k == 4) begin
               n_checks++;
               if (p2[0] !== 1'b1) begin
                  n_fail++;
                  $display("FAIL mhz_latency: phi_2=%b, expected 1", p2[0]);
               end
            end
            for (int i = 0; i < 4; i++) begin
               n_checks++;
               if (p1[i] !== e1[i] || p2[i] !== e2[i]) begin
                  n_fail++;
                  $display("FAIL mhz_model u%0d edge %0d: phi_1=%b phi_2=%b, expected %b %b",
                           i, n, p1[i], p2[i], e1[i], e2[i]);
               end
               if (per == 2) begin
                  c1[i] += int'(p1[i]);
                  c2[i] += int'(p2[i]);
               end
            end
            n_checks++;
            if ((p1 & p2) !== 4'b0000) begin
               n_fail++;
               $display("FAIL mhz_overlap: phi_1=%b phi_2=%b, expected no common bit", p1, p2);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (c1[i] != 25 - dl[i] || c2[i] != 25 - dl[i]) begin
            n_fail++;
            $display("FAIL mhz_width u%0d: phi_1 %0d phi_2 %0d cycles, expected %0d each",
                     i, c1[i], c2[i], 25 - dl[i]);
         end
      end
   endtask

   task automatic test_turbo();
      int c1 [4];
      int c2 [4];
      for (int i = 0; i < 4; i++) begin
         c1[i] = 0;
         c2[i] = 0;
      end
      for (int per = 0; per < 10; per++) begin
         for (int k = 1; k <= 5; k++) begin
            clk1 = (k <= 2);
            tick();
            for (int i = 0; i < 4; i++) begin
               n_checks++;
               if (p1[i] !== e1[i] || p2[i] !== e2[i]) begin
                  n_fail++;
                  $display("FAIL turbo_model u%0d edge %0d: phi_1=%b phi_2=%b, expected %b %b",
                           i, n, p1[i], p2[i], e1[i], e2[i]);
               end
               if (per == 6) begin
                  c1[i] += int'(p1[i]);
                  c2[i] += int'(p2[i]);
               end
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         int x1;
         int x2;
         x1 = (3 > dl[i]) ? 3 - dl[i] : 0;
         x2 = (2 > dl[i]) ? 2 - dl[i] : 0;
         n_checks++;
         if (c1[i] != x1 || c2[i] != x2) begin
            n_fail++;
            $display("FAIL turbo_width u%0d: phi_1 %0d phi_2 %0d cycles, expected %0d %0d",
                     i, c1[i], c2[i], x1, x2);
         end
      end
   endtask

   task automatic test_glitch();
      int low1 [4];
      int hi2  [4];
      for (int i = 0; i < 4; i++) begin
         low1[i] = 0;
         hi2[i]  = 0;
      end
      clk1 = 1'b0;
      repeat (20) tick();
      for (int k = 0; k < 31; k++) begin
         clk1 = (k == 0);
         tick();
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (p1[i] !== e1[i] || p2[i] !== e2[i]) begin
               n_fail++;
               $display("FAIL glitch_model u%0d edge %0d: phi_1=%b phi_2=%b, expected %b %b",
                        i, n, p1[i], p2[i], e1[i], e2[i]);
            end
            low1[i] += int'(!p1[i]);
            hi2[i]  += int'(p2[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (low1[i] != dl[i] + 1 || hi2[i] != 0 || p1[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_reject u%0d: phi_1 low %0d, phi_2 high %0d, final phi_1=%b, expected %0d 0 1",
                     i, low1[i], hi2[i], p1[i], dl[i] + 1);
         end
      end
   endtask

   task automatic test_reset_mid();
      clk1 = 1'b1;
      repeat (40) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (p1[i] !== e1[i] || p2[i] !== e2[i]) begin
               n_fail++;
               $display("FAIL mid_pre u%0d edge %0d: phi_1=%b phi_2=%b, expected %b %b",
                        i, n, p1[i], p2[i], e1[i], e2[i]);
            end
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({p1, p2} !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_async: phi_1=%b phi_2=%b, expected 0000 0000", p1, p2);
      end
      model_reset();
      @(negedge clk);
      repeat (2) begin
         tick();
         n_checks++;
         if ({p1, p2} !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_hold: phi_1=%b phi_2=%b, expected 0000 0000", p1, p2);
         end
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 3 || k == 4) begin
            n_checks++;
            if (p2[0] !== (k == 4)) begin
               n_fail++;
               $display("FAIL mid_rise edge %0d: phi_2=%b, expected %b", k, p2[0], k == 4);
            end
         end
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (p1[i] !== e1[i] || p2[i] !== e2[i]) begin
               n_fail++;
               $display("FAIL mid_model u%0d edge %0d: phi_1=%b phi_2=%b, expected %b %b",
                        i, n, p1[i], p2[i], e1[i], e2[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      bit level;
      int half;
      level = clk1;
      for (int seg = 0; seg < 150; seg++) begin
         level = !level;
         half  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
         clk1  = level;
         repeat (half) begin
            tick();
            for (int i = 0; i < 4; i++) begin
               n_checks++;
               if (p1[i] !== e1[i] || p2[i] !== e2[i]) begin
                  n_fail++;
                  $display("FAIL random_model u%0d edge %0d: phi_1=%b phi_2=%b, expected %b %b",
                           i, n, p1[i], p2[i], e1[i], e2[i]);
               end
            end
            n_checks++;
            if ((p1 & p2) !== 4'b0000) begin
               n_fail++;
               $display("FAIL random_overlap: phi_1=%b phi_2=%b, expected no common bit", p1, p2);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clk1  = 1'b0;
      @(negedge clk);
      test_reset();
      test_1mhz();
      test_turbo();
      test_glitch();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
